aes_cipher_engine: RTL and testbench
====================================

// Module: aes_cipher_engine
// PURPOSE
//  Iterative AES forward cipher. Supports AES-128, AES-192 and AES-256, selected at elaboration.
//  Does one round per clock and exchanges blocks over valid/ready handshakes.
//  Sits between the block-input FIFO and the ciphertext output path.
//  Gets round keys from the key-schedule block through an index/key lookup port.
// PARAMETERS
//  KEY_BITS  128  key length: 128, 192 or 256; any other value -> elaboration $error
//  NR        aes_pkg::nr(KEY_BITS)  round count: 10, 12 or 14; derived, never overridden
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    synchronous, active-high
//  in_valid   in   1    plaintext block offered
//  in_ready   out  1    engine can accept a block
//  in_data    in   128  plaintext, byte 0 = bits [127:120]
//  rk_idx     out  4    index of the round key needed this cycle
//  rk         in   128  round key for rk_idx; combinational, valid in the same cycle
//  out_valid  out  1    ciphertext available
//  out_ready  in   1    consumer takes the ciphertext
//  out_data   out  128  ciphertext, registered
//  busy       out  1    high in RUN or HOLD
// BEHAVIOUR
//  Reset
//   - Clocking: clk, rising edge; reset is synchronous, active-high.
//   - On reset: state <= IDLE, round <= 0, st <= 0, out_valid = 0, busy = 0.
//   - in_ready = 1 from the first cycle after reset is released.
//  FSM
//   - States: IDLE, RUN, HOLD. st[127:0] is the state register; out_data = st.
//   - IDLE:
//     - in_ready = 1, rk_idx = 0.
//     - On in_valid: st <= in_data ^ rk, round <= 1, go to RUN.
//   - RUN:
//     - in_ready = 0, rk_idx = round.
//     - If round < NR: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk, round++.
//     - If round == NR: st <= ShiftRows(SubBytes(st)) ^ rk (final round, no MixColumns), go to HOLD.
//   - HOLD:
//     - out_valid = 1, rk_idx = NR, in_ready = 0.
//     - On out_ready: go to IDLE. The accept happens on the next cycle; there is no same-cycle bypass.
//  Latency and throughput
//   - out_valid rises NR+1 clocks after the accept edge. For AES-128 that is 11.
//   - Minimum block period is NR+2 cycles, counting accept plus HOLD with out_ready tied high.
//  Handshake rules
//   - A transfer occurs only on valid & ready at a rising edge.
//   - out_data and out_valid stay stable in HOLD until out_ready is seen.
//   - in_valid while in_ready = 0 is ignored; the producer must hold it.
//  Boundaries
//   - round counter width: 4 bits; never exceeds NR.
//   - reset mid-RUN or mid-HOLD: the block is aborted and dropped; no out_valid pulse.
//   - out_ready with no out_valid: no effect.
//   - rk is sampled only in IDLE-accept and RUN cycles; ignored elsewhere.
//  Other
//   - All byte arithmetic is GF(2^8) with polynomial 0x11B. No sequential state outside st, round, FSM.
// STRUCTURE
//  aes_pkg (shared)
//   - function nr(int key_bits)
//   - typedef enum logic [1:0] {IDLE, RUN, HOLD} eng_state_t
//   - typedef logic [127:0] aes_block_t
//   - S-box constant table and xtime function
//  Sub-module aes_round (combinational)
//   - Ports: st_in, rk, final_rnd, st_out.
//   - Implements SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey.
//   - Instantiated once.
// TESTING
//  - AES-128, FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff
//    -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
//  - AES-192, FIPS-197 C.2: key 000102..17, same pt
//    -> dda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles.
//  - AES-256, FIPS-197 C.3: key 000102..1f, same pt
//    -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
//  - Backpressure: out_ready low for 20 cycles in HOLD
//    -> out_data stable, in_ready 0 throughout.
//    -> When out_ready goes high, IDLE follows and the next block is accepted the cycle after.
//  - Reset asserted at round 5 of an AES-128 run
//    -> next cycle IDLE, out_valid 0, out_data 0, no spurious result.
//    -> A fresh C.1 run afterwards gives the correct ciphertext.
//  - Back-to-back: 8 random blocks with in_valid and out_ready held high
//    -> all 8 outputs match the reference model, in order, 12 cycles apart for AES-128.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: engine FSM states, block type, round-count helper,
// forward S-box table and GF(2^8) xtime (polynomial 0x11B).
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} eng_state_t;

  typedef logic [127:0] aes_block_t;

  // Round count for a given key length; unsupported lengths fall back to 10
  // and are rejected at elaboration by the engine.
  function automatic int unsigned nr(int key_bits);
    if (key_bits == 192) return 12;
    if (key_bits == 256) return 14;
    return 10;
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES forward round:
// SubBytes -> ShiftRows -> MixColumns (skipped when final_rnd) -> AddRoundKey.
// Ports:
//   st_in     - state entering the round (byte 0 = bits [127:120], column-major)
//   rk        - round key
//   final_rnd - 1 for the last round, which omits MixColumns
//   st_out    - state leaving the round
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t st_in,
  input  aes_block_t rk,
  input  logic       final_rnd,
  output aes_block_t st_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  for (genvar i = 0; i < 16; i++) begin : g_sub_shift
    assign sb[i] = SBOX[st_in[127-8*i -: 8]];
    assign sr[i] = sb[4*(((i/4) + (i%4)) % 4) + (i%4)];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_add_key
    assign st_out[127-8*i -: 8] = (final_rnd ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_cipher_engine.sv
// Iterative AES forward cipher, one round per clock, valid/ready on both sides.
// Round keys come from an external key schedule via rk_idx -> rk (same-cycle lookup).
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   - plaintext handshake, in_data byte 0 = bits [127:120]
//   rk_idx/rk           - round-key index requested this cycle and the returned key
//   out_valid/out_ready - ciphertext handshake, out_data is the state register
//   busy                - high while a block is in RUN or HOLD
module aes_cipher_engine
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_block_t in_data,
  output logic [3:0] rk_idx,
  input  aes_block_t rk,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_block_t out_data,
  output logic       busy
);

  localparam int unsigned NR  = nr(KEY_BITS);
  localparam logic [3:0]  NrW = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_cipher_engine: KEY_BITS must be 128, 192 or 256, got %0d", KEY_BITS);
  end

  eng_state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  aes_block_t st_q, st_d;
  aes_block_t rnd_out;
  logic       final_rnd;

  assign final_rnd = (round_q == NrW);

  aes_round u_round (
    .st_in     (st_q),
    .rk        (rk),
    .final_rnd (final_rnd),
    .st_out    (rnd_out)
  );

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Initial AddRoundKey with key 0 folded into the accept cycle.
          st_d    = in_data ^ rk;
          round_d = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        rk_idx = round_q;
        st_d   = rnd_out;
        if (final_rnd) begin
          state_d = HOLD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        rk_idx    = NrW;
        if (out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
    end
  end

  assign out_data = st_q;

endmodule

// File: tb/tb_aes_cipher_engine.sv
// Bench for aes_cipher_engine: one instance per key length, each fed by a
// bench-side key schedule built from an independently generated S-box.
module tb_aes_cipher_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic [3:0]   rk_idx    [3];
  logic [127:0] rk        [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  logic [127:0] rks    [3][16];
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_q  [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cur = 0;
  int last_cyc = -1;
  bit spacing_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rk[g] = rks[g][rk_idx[g]];
    aes_cipher_engine #(.KEY_BITS(128 + 64*g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .rk_idx    (rk_idx[g]),
      .rk        (rk[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(string name, logic [127:0] act, logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic check_int(string name, int act, int want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] v;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      v   = 8'(x);
      inv = 8'h00;
      if (v != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, v);
      end
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key bytes are 00, 01, 02, ... as in the FIPS-197 appendix C examples.
  task automatic expand(int k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nrk;
    nk  = 4 + 2*k;
    nrk = nk + 6;
    rc  = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nrk+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nrk) rks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else rks[k][r] = '0;
    end
  endtask

  function automatic logic [127:0] ref_enc(int k, logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    int nrk;
    nrk = 10 + 2*k;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[k][0][127-8*i -: 8];
    for (int r = 1; r <= nrk; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < nrk) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) t[row] = s[4*c+row];
          s[4*c]   = gmul(t[0], 8'h02) ^ gmul(t[1], 8'h03) ^ t[2] ^ t[3];
          s[4*c+1] = t[0] ^ gmul(t[1], 8'h02) ^ gmul(t[2], 8'h03) ^ t[3];
          s[4*c+2] = t[0] ^ t[1] ^ gmul(t[2], 8'h02) ^ gmul(t[3], 8'h03);
          s[4*c+3] = gmul(t[0], 8'h03) ^ t[1] ^ t[2] ^ gmul(t[3], 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[k][r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Scoreboard: every output handshake of the active instance pops one entry.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid[cur] === 1'b1 && out_ready[cur] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got %h expected no output", out_data[cur]);
        end else begin
          check("ciphertext", out_data[cur], exp_q.pop_front());
          if (spacing_en && last_cyc >= 0) check_int("b2b_spacing", cyc - last_cyc, 12);
          last_cyc = cyc;
        end
      end
    end
  end

  // Present a block from the next cycle on; returns after the accepting edge.
  task automatic send(int k, logic [127:0] pt, output bit ok);
    @(posedge clk);
    #1;
    in_data[k]  = pt;
    in_valid[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[k] === 1'b1) ok = 1'b1;
    end
    if (!ok) check_int("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check_int(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Latency counts clock cycles from the accept cycle to the first out_valid cycle.
  task automatic run_one(int k, logic [127:0] pt, logic [127:0] want, int lat_want);
    bit ok;
    int lat;
    cur = k;
    exp_q.push_back(want);
    send(k, pt, ok);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid[k] === 1'b1) break;
    end
    check_int("latency", lat, lat_want);
    drain("drain");
  endtask

  typedef struct {
    int           k;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    vec_t         vecs [3];
    bit           ok;
    bit           got;
    logic [127:0] blk;

    vecs[0] = '{k: 0, pt: PT, ct: C1, lat: 11};
    vecs[1] = '{k: 1, pt: PT, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, lat: 13};
    vecs[2] = '{k: 2, pt: PT, ct: 128'h8ea2b7ca516745bfeafc49904b496089, lat: 15};

    build_sbox();
    for (int k = 0; k < 3; k++) expand(k);

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_int("rst_in_ready", int'(in_ready[k]), 1);
      check_int("rst_out_valid", int'(out_valid[k]), 0);
      check_int("rst_busy", int'(busy[k]), 0);
      check_int("rst_rk_idx", int'(rk_idx[k]), 0);
      check("rst_out_data", out_data[k], '0);
    end

    for (int v = 0; v < 3; v++) run_one(vecs[v].k, vecs[v].pt, vecs[v].ct, vecs[v].lat);

    // Backpressure: HOLD for 20 cycles with a second block already offered.
    cur = 0;
    out_ready[0] = 1'b0;
    exp_q.push_back(C1);
    send(0, PT, ok);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) got = 1'b1;
    end
    check_int("bp_reach_hold", int'(got), 1);
    @(posedge clk);
    #1;
    blk = 128'h0123456789abcdeffedcba9876543210;
    in_data[0]  = blk;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_int("bp_out_valid", int'(out_valid[0]), 1);
      check_int("bp_in_ready", int'(in_ready[0]), 0);
      check_int("bp_busy", int'(busy[0]), 1);
      check("bp_out_data", out_data[0], C1);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_int("bp_idle_in_ready", int'(in_ready[0]), 1);
    check_int("bp_idle_out_valid", int'(out_valid[0]), 0);
    check_int("bp_idle_busy", int'(busy[0]), 0);
    exp_q.push_back(ref_enc(0, blk));
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check_int("bp_next_busy", int'(busy[0]), 1);
    check_int("bp_next_in_ready", int'(in_ready[0]), 0);
    drain("bp_drain");

    // Reset in the middle of round 5 drops the block.
    cur = 0;
    send(0, PT, ok);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rk_idx[0] === 4'd5) got = 1'b1;
    end
    check_int("rst_round5_reached", int'(got), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_int("midrst_in_ready", int'(in_ready[0]), 1);
    check_int("midrst_out_valid", int'(out_valid[0]), 0);
    check_int("midrst_busy", int'(busy[0]), 0);
    check("midrst_out_data", out_data[0], '0);
    repeat (20) @(negedge clk);
    run_one(0, PT, C1, 11);

    // Back-to-back random blocks, in_valid and out_ready held high.
    cur = 0;
    spacing_en = 1'b1;
    last_cyc = -1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      in_data[0] = blk;
      ok = 1'b0;
      for (int j = 0; j < 50 && !ok; j++) begin
        @(negedge clk);
        if (in_ready[0] === 1'b1) ok = 1'b1;
      end
      check_int("b2b_accept", int'(ok), 1);
      exp_q.push_back(ref_enc(0, blk));
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    drain("b2b_drain");
    spacing_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
